data_mem_ws: RTL and testbench

//   Parametrised data memory for the single-cycle RV32I SoC. It replaces the zero-latency

---
 rtl/data_mem_ws_pkg.sv | 13 +
 rtl/data_mem_ws_sram_bank.sv | 25 ++
 rtl/data_mem_ws.sv | 123 ++++++++++++
 tb/tb_data_mem_ws.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ws_pkg.sv
// rtl/data_mem_ws_pkg.sv - shared FSM encodings and widths for data_mem_ws
package data_mem_ws_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int ADDR_W      = 32;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/data_mem_ws_sram_bank.sv
// rtl/data_mem_ws_sram_bank.sv - DEPTH x DATA_W array, per-byte synchronous write, asynchronous read
module data_mem_ws_sram_bank #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [DATA_W/8-1:0]      i_be,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < DATA_W/8; k++) begin
            if (i_we && i_be[k]) r_mem[i_idx][8*k +: 8] <= i_wdata[8*k +: 8];
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_ws.sv
// rtl/data_mem_ws.sv - wait-state data memory with ce/ready handshake and byte strobes
// Optional last-write verify port enabled by DMEM_VERIFY_EN.
module data_mem_ws
  import data_mem_ws_pkg::*;
#(
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                ready
`ifdef DMEM_VERIFY_EN
  ,
  output logic [DATA_W-1:0]   verify
`endif
);

  localparam int         BE_W      = DATA_W/8;
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  dmem_state_e       r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_data_o;
  logic [DATA_W-1:0] w_rdata;
  logic [IDX_W-1:0]  w_idx;
  logic              w_req_we;
  logic              w_commit;
  logic              w_unused_addr;

  assign w_unused_addr = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};

  // In IDLE the live request is used so a zero-wait read can be registered on RESP entry.
  assign w_idx    = (r_state == DMEM_IDLE) ? addr[IDX_W+1:2] : r_idx;
  assign w_req_we = (r_state == DMEM_IDLE) ? we : r_we;
  assign w_commit = (r_state == DMEM_RESP) && r_we;

  always_comb begin
    w_next = r_state;
    case (r_state)
      DMEM_IDLE: if (ce) w_next = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
      DMEM_WAIT: begin
        if (!ce)                    w_next = DMEM_IDLE;
        else if (r_cnt == WAIT_LAST) w_next = DMEM_RESP;
      end
      DMEM_RESP: w_next = DMEM_IDLE;
      default:   w_next = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= DMEM_IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_data_o <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DMEM_IDLE && ce) begin
        r_we    <= we;
        r_be    <= be;
        r_idx   <= addr[IDX_W+1:2];
        r_wdata <= data_i;
        r_cnt   <= 4'd1;
      end else if (r_state == DMEM_WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_next == DMEM_RESP && !w_req_we) r_data_o <= w_rdata;
      else                                   r_data_o <= '0;
    end
  end

  data_mem_ws_sram_bank #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_bank (
    .clk     (clk),
    .i_we    (w_commit),
    .i_be    (r_be),
    .i_idx   (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign data_o = r_data_o;
  assign ready  = (r_state == DMEM_RESP);

`ifdef DMEM_VERIFY_EN
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] r_verify;

  always_comb begin
    w_merged = w_rdata;
    for (int k = 0; k < BE_W; k++) begin
      if (r_be[k]) w_merged[8*k +: 8] = r_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_verify <= '0;
    else if (w_commit) r_verify <= w_merged;
  end

  assign verify = r_verify;
`endif

endmodule

// File: tb/tb_data_mem_ws.sv
// tb/tb_data_mem_ws.sv - self-checking bench for data_mem_ws (2-wait and 0-wait instances)
module tb_data_mem_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce     [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] addr   [2];
  logic [31:0] data_i [2];
  logic [31:0] data_o [2];
  logic        ready  [2];
`ifdef DMEM_VERIFY_EN
  logic [31:0] verify [2];
`endif

  int          checks   = 0;
  int          failures = 0;
  int unsigned wait_of [2] = '{2, 0};
  logic [31:0] model_mem [2][1024];

  always #5 clk = ~clk;

  data_mem_ws #(.DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(2), .INIT_FILE("")) dut_w2 (
    .clk(clk), .rst(rst), .ce(ce[0]), .we(we[0]), .be(be[0]), .addr(addr[0]),
    .data_i(data_i[0]), .data_o(data_o[0]), .ready(ready[0])
`ifdef DMEM_VERIFY_EN
    , .verify(verify[0])
`endif
  );

  data_mem_ws #(.DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0), .INIT_FILE("")) dut_w0 (
    .clk(clk), .rst(rst), .ce(ce[1]), .we(we[1]), .be(be[1]), .addr(addr[1]),
    .data_i(data_i[1]), .data_o(data_o[1]), .ready(ready[1])
`ifdef DMEM_VERIFY_EN
    , .verify(verify[1])
`endif
  );

  typedef struct {
    int          s;
    bit          w;
    logic [3:0]  b;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [31:0] exp_ver;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Starts in an idle cycle (#1 after a posedge); ends one idle cycle after ready.
  task automatic transact(input int s, input bit w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d, input bit scr,
                          output logic [31:0] rd, output int lat, output bit ok);
    ce[s] = 1'b1; we[s] = w; be[s] = b; addr[s] = a; data_i[s] = d;
    @(posedge clk); #1;
    if (scr) begin
      we[s] = 1'($urandom); be[s] = 4'($urandom); addr[s] = $urandom; data_i[s] = $urandom;
    end
    lat = 0;
    while (!ready[s] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = ready[s];
    rd = data_o[s];
    ce[s] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_req(input int s, input bit w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd,
                         input logic [31:0] exp_ver, input bit scr, input string tag);
    logic [31:0] rd;
    int          lat;
    bit          ok;
    int          idx;
    transact(s, w, b, a, d, scr, rd, lat, ok);
    chk({tag, " ready"}, 32'(ok), 32'd1);
    if (ok) chk({tag, " latency"}, 32'(lat), 32'(wait_of[s]));
    if (ok && !w) chk({tag, " data_o"}, rd, exp_rd);
    chk({tag, " idle data_o"}, data_o[s], 32'h0);
`ifdef DMEM_VERIFY_EN
    if (w) chk({tag, " verify"}, verify[s], exp_ver);
`else
    if (exp_ver === 32'hx) $display("note: unexpected X in expected verify value");
`endif
    if (w) begin
      idx = int'((a >> 2) % 1024);
      model_mem[s][idx] = merge(model_mem[s][idx], d, b);
    end
  endtask

  initial begin
    vec_t        tbl [$];
    int          nrdy;
    int          to;
    int          s, idx;
    bit          w;
    logic [3:0]  b;
    logic [31:0] a, d, m;

    tbl.push_back('{0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF});
    tbl.push_back('{0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 32'h0});
    tbl.push_back('{0, 1'b1, 4'hF, 32'h0000_0020, 32'h11223344, 32'h0,        32'h11223344});
    tbl.push_back('{0, 1'b1, 4'h5, 32'h0000_0020, 32'hAABBCCDD, 32'h0,        32'h11BB33DD});
    tbl.push_back('{0, 1'b0, 4'h0, 32'h0000_0020, 32'h0,        32'h11BB33DD, 32'h0});
    tbl.push_back('{0, 1'b1, 4'hF, 32'h0000_0024, 32'h55667788, 32'h0,        32'h55667788});
    tbl.push_back('{0, 1'b1, 4'h0, 32'h0000_0024, 32'hFFFFFFFF, 32'h0,        32'h55667788});
    tbl.push_back('{0, 1'b0, 4'hF, 32'h0000_0024, 32'h0,        32'h55667788, 32'h0});
    tbl.push_back('{1, 1'b1, 4'hF, 32'h0000_0004, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D});
    tbl.push_back('{1, 1'b0, 4'hF, 32'h0000_1004, 32'h0,        32'hCAFEF00D, 32'h0});
    tbl.push_back('{1, 1'b1, 4'hF, 32'h0000_2008, 32'h01020304, 32'h0,        32'h01020304});
    tbl.push_back('{1, 1'b0, 4'hF, 32'h0000_000B, 32'h0,        32'h01020304, 32'h0});
    tbl.push_back('{1, 1'b1, 4'h3, 32'hFFFF_F008, 32'hA5A5A5A5, 32'h0,        32'h0102A5A5});
    tbl.push_back('{1, 1'b0, 4'h0, 32'h0000_0008, 32'h0,        32'h0102A5A5, 32'h0});

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ce[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; data_i[i] = 32'h0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset ready", 32'(ready[i]), 32'h0);
      chk("reset data_o", data_o[i], 32'h0);
`ifdef DMEM_VERIFY_EN
      chk("reset verify", verify[i], 32'h0);
`endif
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i])
      run_req(tbl[i].s, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, tbl[i].exp_rd,
              tbl[i].exp_ver, 1'b0, $sformatf("vec%0d", i));

    // Abort: ce dropped in the first and in the last wait cycle.
    for (int dly = 0; dly < 2; dly++) begin
      ce[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h10; data_i[0] = 32'h12345678;
      @(posedge clk); #1;
      for (int j = 0; j < dly; j++) begin @(posedge clk); #1; end
      ce[0] = 1'b0;
      nrdy = 0;
      for (int j = 0; j < 5; j++) begin
        @(posedge clk); #1;
        if (ready[0]) nrdy++;
      end
      chk($sformatf("abort%0d no ready", dly), 32'(nrdy), 32'h0);
      run_req(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0,
              $sformatf("abort%0d reread", dly));
    end

    // Asynchronous reset mid-cycle while a read response is on the bus.
    ce[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    @(posedge clk); #1;
    to = 0;
    while (!ready[0] && to < 40) begin @(posedge clk); #1; to++; end
    chk("pre-reset data_o", data_o[0], 32'hDEADBEEF);
    #2 rst = 1'b0; ce[0] = 1'b0;
    #1;
    chk("async reset ready", 32'(ready[0]), 32'h0);
    chk("async reset data_o", data_o[0], 32'h0);
`ifdef DMEM_VERIFY_EN
    chk("async reset verify", verify[0], 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset while a write sits in WAIT: no partial commit, next read normal.
    ce[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h20; data_i[0] = 32'h0;
    @(posedge clk); #1;
    #2 rst = 1'b0; ce[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_req(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 32'h0, 1'b0, "post-reset read");

    // Random traffic over a small aliased window, inputs scrambled in flight.
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 16; k++) begin
        d = $urandom;
        run_req(i, 1'b1, 4'hF, 32'(k << 2), d, 32'h0, d, 1'b0, "rand init");
      end
    for (int n = 0; n < 150; n++) begin
      s   = int'($urandom_range(1, 0));
      w   = 1'($urandom);
      b   = 4'($urandom);
      idx = int'($urandom_range(15, 0));
      a   = ($urandom & 32'hFFFF_F000) | 32'(idx << 2) | 32'($urandom_range(3, 0));
      d   = $urandom;
      m   = merge(model_mem[s][idx], d, b);
      run_req(s, w, b, a, d, model_mem[s][idx], m, 1'b1, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
